// File: rtl/pc_run_controller.sv
`default_nettype none
// ============================================================================
//  Module   : pc_run_controller
//  Purpose  : Run/stop/step/byte-load sequencer for the program counter.
//             Converts debounced push-button levels into commands, gates the
//             slow tick into the PC count enable, drives the PC load port and
//             halts on an optional breakpoint address.
//  Revision : 1.0 - initial release
// ============================================================================
module pc_run_controller #(
  parameter int SIZE = 16
) (
  input  logic              clock,
  input  logic              rst,
  input  logic              run_req,
  input  logic              stop_req,
  input  logic              step_req,
  input  logic              ldhi_req,
  input  logic              ldlo_req,
  input  logic              tick,
  input  logic [SIZE/2-1:0] datain,
  input  logic [SIZE-1:0]   curpc,
  input  logic [SIZE-1:0]   brk_addr,
  input  logic              brk_valid,
  output logic              pc_en,
  output logic              pc_aload,
  output logic [SIZE-1:0]   pc_d,
  output logic [2:0]        state,
  output logic              running
);

  localparam int HALF = SIZE / 2;

  typedef enum logic [2:0] {
    ST_STOP = 3'd0,
    ST_RUN  = 3'd1,
    ST_STEP = 3'd2,
    ST_LOAD = 3'd3,
    ST_BRK  = 3'd4
  } state_t;

  state_t            state_q, state_d;
  state_t            ret_q, ret_d;
  logic              skip_q, skip_d;
  logic [SIZE-1:0]   pc_d_q, pc_d_d;
  logic              aload_q, aload_d;

  // Request levels packed in priority order: bit 0 is the highest priority.
  logic [4:0] lvl;
  logic [4:0] prev_q;
  logic [4:0] raw_edge;
  logic       cmd_stop, cmd_ldhi, cmd_ldlo, cmd_run, cmd_step, cmd_load;
  logic       hit;
  logic       load_take;

  assign lvl      = {step_req, run_req, ldlo_req, ldhi_req, stop_req};
  assign raw_edge = lvl & ~prev_q;

  // Only the highest-priority edge of a cycle survives; the rest are dropped.
  assign cmd_stop = raw_edge[0];
  assign cmd_ldhi = raw_edge[1] & ~raw_edge[0];
  assign cmd_ldlo = raw_edge[2] & ~(|raw_edge[1:0]);
  assign cmd_run  = raw_edge[3] & ~(|raw_edge[2:0]);
  assign cmd_step = raw_edge[4] & ~(|raw_edge[3:0]);
  assign cmd_load = cmd_ldhi | cmd_ldlo;

  // skip masks the breakpoint right after resuming or loading onto it.
  assign hit = brk_valid & (curpc == brk_addr) & ~skip_q;

  // Previous-level registers; tracking the level during reset means a button
  // held through reset does not fire a command on release of reset.
  always_ff @(posedge clock) begin
    prev_q <= lvl;
  end

  // Next-state, enable and load-data decode.
  always_comb begin
    state_d   = state_q;
    ret_d     = ret_q;
    skip_d    = skip_q;
    pc_d_d    = pc_d_q;
    aload_d   = 1'b0;
    pc_en     = 1'b0;
    load_take = 1'b0;
    case (state_q)
      ST_STOP: begin
        if (cmd_load) begin
          state_d   = ST_LOAD;
          ret_d     = ST_STOP;
          load_take = 1'b1;
        end else if (cmd_run) begin
          state_d = ST_RUN;
          skip_d  = 1'b0;
        end else if (cmd_step) begin
          state_d = ST_STEP;
        end
      end
      ST_RUN: begin
        if (cmd_stop) begin
          state_d = ST_STOP;
        end else if (cmd_load) begin
          state_d   = ST_LOAD;
          ret_d     = ST_RUN;
          load_take = 1'b1;
        end else if (hit) begin
          state_d = ST_BRK;
        end else if (tick) begin
          pc_en  = 1'b1;
          skip_d = 1'b0;
        end
      end
      ST_STEP: begin
        if (cmd_stop) begin
          state_d = ST_STOP;
        end else if (cmd_load) begin
          state_d   = ST_LOAD;
          ret_d     = ST_STOP;
          load_take = 1'b1;
        end else if (tick) begin
          pc_en   = 1'b1;
          state_d = ST_STOP;
        end
      end
      ST_LOAD: begin
        state_d = ret_q;
        if (ret_q == ST_RUN) begin
          skip_d = 1'b1;
        end
      end
      ST_BRK: begin
        if (cmd_stop) begin
          state_d = ST_STOP;
        end else if (cmd_load) begin
          state_d   = ST_LOAD;
          ret_d     = ST_STOP;
          load_take = 1'b1;
        end else if (cmd_run) begin
          state_d = ST_RUN;
          skip_d  = 1'b1;
        end else if (cmd_step) begin
          state_d = ST_STEP;
        end
      end
      default: begin
        state_d = ST_STOP;
      end
    endcase

    if (load_take) begin
      pc_d_d  = cmd_ldhi ? {datain, curpc[HALF-1:0]} : {curpc[SIZE-1:HALF], datain};
      aload_d = 1'b1;
    end
  end

  // State and load-port registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!rst) begin
      state_q <= ST_STOP;
      ret_q   <= ST_STOP;
      skip_q  <= 1'b0;
      pc_d_q  <= '0;
      aload_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ret_q   <= ret_d;
      skip_q  <= skip_d;
      pc_d_q  <= pc_d_d;
      aload_q <= aload_d;
    end
  end

  assign pc_aload = aload_q;
  assign pc_d     = pc_d_q;
  assign state    = state_q;
  assign running  = (state_q == ST_RUN);

endmodule
`default_nettype wire

// File: tb/tb_pc_run_controller.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pc_run_controller
//  Purpose  : Directed scoreboard bench for pc_run_controller. Expected PC
//             enable / load events are queued by the stimulus process and
//             popped by a monitor whenever the DUT strobes pc_en or pc_aload.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pc_run_controller;

  localparam int SIZE = 16;

  logic              clock = 1'b0;
  logic              rst;
  logic              run_req, stop_req, step_req, ldhi_req, ldlo_req;
  logic              tick;
  logic [SIZE/2-1:0] datain;
  logic [SIZE-1:0]   curpc, brk_addr;
  logic              brk_valid;
  logic              pc_en, pc_aload;
  logic [SIZE-1:0]   pc_d;
  logic [2:0]        state;
  logic              running;

  typedef struct {
    bit              is_load;
    logic [SIZE-1:0] d;
    logic [2:0]      st;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  pc_run_controller #(.SIZE(SIZE)) dut (
    .clock     (clock),
    .rst       (rst),
    .run_req   (run_req),
    .stop_req  (stop_req),
    .step_req  (step_req),
    .ldhi_req  (ldhi_req),
    .ldlo_req  (ldlo_req),
    .tick      (tick),
    .datain    (datain),
    .curpc     (curpc),
    .brk_addr  (brk_addr),
    .brk_valid (brk_valid),
    .pc_en     (pc_en),
    .pc_aload  (pc_aload),
    .pc_d      (pc_d),
    .state     (state),
    .running   (running)
  );

  always #5 clock = ~clock;

  // Monitor: every enable/load strobe must match the head of the queue.
  always @(negedge clock) begin
    if (rst && (pc_en || pc_aload)) begin
      n_checks++;
      if (pc_en && pc_aload) begin
        n_fail++;
        $display("FAIL en_aload_exclusive: pc_en=%0b pc_aload=%0b required not both", pc_en, pc_aload);
      end
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_strobe @%0t: pc_en=%0b pc_aload=%0b state=%0d required no strobe",
                 $time, pc_en, pc_aload, state);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if ((pc_aload != e.is_load) || (state != e.st) || (e.is_load && (pc_d != e.d))) begin
          n_fail++;
          $display("FAIL strobe @%0t: got aload=%0b state=%0d pc_d=%h required aload=%0b state=%0d pc_d=%h",
                   $time, pc_aload, state, pc_d, e.is_load, e.st, e.d);
        end
      end
    end
  end

  task automatic step_clk();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
    n_checks++;
    if (got !== req) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, got, req);
    end
  endtask

  task automatic push_en(input logic [2:0] st);
    exp_t e;
    e.is_load = 1'b0;
    e.d       = '0;
    e.st      = st;
    exp_q.push_back(e);
  endtask

  task automatic push_load(input logic [SIZE-1:0] d);
    exp_t e;
    e.is_load = 1'b1;
    e.d       = d;
    e.st      = 3'd3;
    exp_q.push_back(e);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; run_req = 1'b1; stop_req = 1'b0; step_req = 1'b0;
    ldhi_req = 1'b0; ldlo_req = 1'b0; tick = 1'b0; datain = '0;
    curpc = '0; brk_addr = '0; brk_valid = 1'b0;

    // 1. Reset with run held: release must not start the run.
    repeat (3) step_clk();
    rst = 1'b1;
    repeat (3) step_clk();
    chk("reset_state", 32'(state), 32'd0);
    chk("reset_running", 32'(running), 32'd0);
    chk("reset_pc_d", 32'(pc_d), 32'h0);
    run_req = 1'b0;
    step_clk();

    // 2. Run, four ticks, then stop.
    run_req = 1'b1; step_clk(); run_req = 1'b0;
    chk("run_state", 32'(state), 32'd1);
    chk("run_running", 32'(running), 32'd1);
    for (int i = 0; i < 4; i++) begin
      repeat (7) step_clk();
      push_en(3'd1);
      tick = 1'b1; step_clk(); tick = 1'b0;
    end
    stop_req = 1'b1; step_clk(); stop_req = 1'b0;
    chk("stop_state", 32'(state), 32'd0);
    tick = 1'b1; step_clk(); tick = 1'b0;
    step_clk();
    chk("stop_running", 32'(running), 32'd0);

    // 3. Single step, then a step cancelled by stop.
    step_req = 1'b1; step_clk(); step_req = 1'b0;
    chk("step_state", 32'(state), 32'd2);
    repeat (4) step_clk();
    push_en(3'd2);
    tick = 1'b1; step_clk(); tick = 1'b0;
    chk("step_done_state", 32'(state), 32'd0);
    step_req = 1'b1; step_clk(); step_req = 1'b0;
    chk("step2_state", 32'(state), 32'd2);
    stop_req = 1'b1; step_clk(); stop_req = 1'b0;
    chk("step_cancel_state", 32'(state), 32'd0);
    tick = 1'b1; step_clk(); tick = 1'b0;
    step_clk();

    // 4. Byte loads.
    curpc = 16'h12AB; datain = 8'h3C;
    push_load(16'h3CAB);
    ldhi_req = 1'b1; step_clk(); ldhi_req = 1'b0;
    chk("ldhi_state", 32'(state), 32'd3);
    step_clk();
    chk("ldhi_ret_state", 32'(state), 32'd0);
    chk("ldhi_pc_d_hold", 32'(pc_d), 32'h3CAB);
    push_load(16'h123C);
    ldlo_req = 1'b1; step_clk(); ldlo_req = 1'b0;
    step_clk();
    chk("ldlo_pc_d", 32'(pc_d), 32'h123C);
    push_load(16'h3CAB);
    ldhi_req = 1'b1; ldlo_req = 1'b1; step_clk(); ldhi_req = 1'b0; ldlo_req = 1'b0;
    repeat (2) step_clk();
    chk("both_pc_d", 32'(pc_d), 32'h3CAB);
    chk("both_state", 32'(state), 32'd0);

    // 5. Breakpoint halt, resume with skip, halt again.
    curpc = 16'h0005; brk_addr = 16'h0005; brk_valid = 1'b1;
    run_req = 1'b1; step_clk(); run_req = 1'b0;
    chk("brk_run_state", 32'(state), 32'd1);
    tick = 1'b1; step_clk(); tick = 1'b0;
    chk("brk_hit_state", 32'(state), 32'd4);
    run_req = 1'b1; step_clk(); run_req = 1'b0;
    chk("brk_resume_state", 32'(state), 32'd1);
    push_en(3'd1);
    tick = 1'b1; step_clk(); tick = 1'b0;
    curpc = 16'h0006;
    repeat (3) step_clk();
    chk("brk_past_state", 32'(state), 32'd1);
    curpc = 16'h0005;
    step_clk();
    chk("brk_rehit_state", 32'(state), 32'd4);
    chk("brk_rehit_running", 32'(running), 32'd0);

    // 6. Load edge and tick together while running.
    brk_valid = 1'b0;
    run_req = 1'b1; step_clk(); run_req = 1'b0;
    chk("ldrun_run_state", 32'(state), 32'd1);
    push_load(16'h003C);
    ldlo_req = 1'b1; tick = 1'b1; step_clk(); ldlo_req = 1'b0; tick = 1'b0;
    chk("ldrun_load_state", 32'(state), 32'd3);
    step_clk();
    chk("ldrun_ret_state", 32'(state), 32'd1);
    chk("ldrun_running", 32'(running), 32'd1);
    stop_req = 1'b1; step_clk(); stop_req = 1'b0;
    chk("final_stop_state", 32'(state), 32'd0);

    repeat (2) step_clk();
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
